maxpool2d_2x2_stride2_1x_64ch: RTL and testbench



---
 rtl/maxpool2d_2x2_stride2_1x_64ch.sv | 231 +++++++++++++++++++++++
 tb/tb_maxpool2d_2x2_stride2_1x_64ch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_2x2_stride2_1x_64ch.sv
// maxpool2d_2x2_stride2_1x_64ch
//
// Purpose:
//    Downstream pooling stage for a 64-channel activation layer. On start it
//    kicks the upstream layer, waits for it to finish, then walks the upstream
//    IN_W x IN_H x CH nibble map one 2x2 window at a time, keeps the unsigned
//    maximum of each window and packs eight results per 32-bit word into an
//    internal memory. The pooled map is readable through a nibble-addressed
//    port with the same shape as the upstream one, so layers can be chained.
//
// Ports:
//    clk           clock
//    reset         asynchronous active-high reset
//    start         single-cycle pulse, begins a run when idle
//    up_start      single-cycle start pulse to the upstream layer
//    up_done       upstream completion pulse (only honoured while waiting)
//    up_read_addr  upstream nibble address (ch*IN_W*IN_H + row*IN_W + col)
//    up_read_data  upstream nibble, valid one cycle after up_read_addr
//    read_addr     pooled nibble address (ch*OW*OH + r*OW + c)
//    read_data     pooled nibble, registered, valid one cycle after read_addr
//    busy          high from accepted start through the done cycle
//    done          single-cycle completion pulse
module maxpool2d_2x2_stride2_1x_64ch #(
    parameter int IN_W = 16,
    parameter int IN_H = 16,
    parameter int CH   = 64,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          up_start,
    input  logic          up_done,
    output logic [31:0]   up_read_addr,
    input  logic [DW-1:0] up_read_data,
    input  logic [31:0]   read_addr,
    output logic [DW-1:0] read_data,
    output logic          busy,
    output logic          done
);

    localparam int OW    = IN_W / 2;
    localparam int OH    = IN_H / 2;
    localparam int NOUT  = CH * OW * OH;
    localparam int NPW   = 32 / DW;
    localparam int WORDS = NOUT / NPW;
    localparam int CW    = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW    = (OH > 1) ? $clog2(OH) : 1;
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int OIW   = $clog2(NOUT);
    localparam int SLW   = $clog2(NPW);

    localparam logic [CW-1:0]  C_LAST    = CW'(OW - 1);
    localparam logic [RW-1:0]  R_LAST    = RW'(OH - 1);
    localparam logic [OIW-1:0] OUT_LAST  = OIW'(NOUT - 1);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(NPW - 1);

    // Every channel plane must fill whole words so no partial word is left
    // sitting in the pack register at the end of a run.
    if ((OW * OH) % NPW != 0) begin : gBadGeometry
        $error("pooled plane size must be a multiple of the nibbles per word");
    end

    typedef enum logic [3:0] {
        IDLE, START_UP, WAIT_UP, RD0, RD1, RD2, RD3, RD_DRAIN, WRITE, DONE
    } state_t;

    state_t           state_q;
    logic             busy_q, done_q, upStart_q;
    logic [31:0]      upAddr_q;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    c_q, c_d;
    logic [OIW-1:0]   outIdx_q;
    logic [DW-1:0]    max_q;
    logic [31:0]      pack_q, pack_d;
    logic [DW-1:0]    readData_q;
    logic             cWrap, rWrap, lastOut, memWe, capture;
    logic [31:0]      rdWord;
    logic [DW-1:0]    rdNibble;
    logic             rdInRange;
    logic [31:0]      mem [WORDS];

    // Upstream address of one tap of window (ch, r, c); tap bit 1 selects the
    // lower row and tap bit 0 the right column, giving the order TL, TR, BL, BR.
    function automatic logic [31:0] tapAddr(input logic [CHW-1:0] chV,
                                            input logic [RW-1:0]  rV,
                                            input logic [CW-1:0]  cV,
                                            input logic [1:0]     tap);
        logic [31:0] row;
        logic [31:0] col;
        row = {{(32-RW){1'b0}}, rV} * 32'd2 + {31'd0, tap[1]};
        col = {{(32-CW){1'b0}}, cV} * 32'd2 + {31'd0, tap[0]};
        return {{(32-CHW){1'b0}}, chV} * 32'(IN_W * IN_H) + row * 32'(IN_W) + col;
    endfunction

    // Window position after the current one: column first, then row, then channel.
    always_comb begin
        cWrap   = (c_q == C_LAST);
        rWrap   = (r_q == R_LAST);
        c_d     = cWrap ? '0 : c_q + CW'(1);
        r_d     = r_q;
        ch_d    = ch_q;
        if (cWrap) begin
            r_d = rWrap ? '0 : r_q + RW'(1);
            if (rWrap) begin
                ch_d = ch_q + CHW'(1);
            end
        end
        lastOut = (outIdx_q == OUT_LAST);
    end

    // The finished window maximum merged into its slot; slot 0 is the top
    // nibble of the word. The word is committed once its last slot is filled.
    always_comb begin
        pack_d = pack_q;
        pack_d[DW*(NPW-1-int'(outIdx_q[SLW-1:0])) +: DW] = max_q;
        memWe   = (state_q == WRITE) && (outIdx_q[SLW-1:0] == SLOT_LAST);
        capture = (state_q == RD1) || (state_q == RD2) ||
                  (state_q == RD3) || (state_q == RD_DRAIN);
    end

    // Control FSM; all handshake outputs are registered and set on the edge
    // that enters the state in which they must be visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            upStart_q <= 1'b0;
            upAddr_q  <= '0;
            ch_q      <= '0;
            r_q       <= '0;
            c_q       <= '0;
            outIdx_q  <= '0;
            max_q     <= '0;
            pack_q    <= '0;
        end else begin
            upStart_q <= 1'b0;
            done_q    <= 1'b0;
            if (capture && (up_read_data > max_q)) begin
                max_q <= up_read_data;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= START_UP;
                        busy_q    <= 1'b1;
                        upStart_q <= 1'b1;
                    end
                end
                START_UP: state_q <= WAIT_UP;
                WAIT_UP: begin
                    if (up_done) begin
                        ch_q     <= '0;
                        r_q      <= '0;
                        c_q      <= '0;
                        outIdx_q <= '0;
                        max_q    <= '0;
                        pack_q   <= '0;
                        upAddr_q <= tapAddr('0, '0, '0, 2'd0);
                        state_q  <= RD0;
                    end
                end
                RD0: begin
                    upAddr_q <= tapAddr(ch_q, r_q, c_q, 2'd1);
                    state_q  <= RD1;
                end
                RD1: begin
                    upAddr_q <= tapAddr(ch_q, r_q, c_q, 2'd2);
                    state_q  <= RD2;
                end
                RD2: begin
                    upAddr_q <= tapAddr(ch_q, r_q, c_q, 2'd3);
                    state_q  <= RD3;
                end
                RD3:      state_q <= RD_DRAIN;
                RD_DRAIN: state_q <= WRITE;
                WRITE: begin
                    pack_q   <= memWe ? '0 : pack_d;
                    max_q    <= '0;
                    outIdx_q <= outIdx_q + OIW'(1);
                    ch_q     <= ch_d;
                    r_q      <= r_d;
                    c_q      <= c_d;
                    if (lastOut) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        upAddr_q <= tapAddr(ch_d, r_d, c_d, 2'd0);
                        state_q  <= RD0;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result storage is deliberately not reset so earlier results survive.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[outIdx_q[OIW-1:SLW]] <= pack_d;
        end
    end

    // Read port is independent of the FSM; out-of-range addresses read as 0.
    always_comb begin
        rdInRange = (read_addr < 32'(NOUT));
        rdWord    = mem[read_addr[OIW-1:SLW]];
        rdNibble  = rdWord[DW*(NPW-1-int'(read_addr[SLW-1:0])) +: DW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData_q <= '0;
        end else begin
            readData_q <= rdInRange ? rdNibble : '0;
        end
    end

    assign up_start     = upStart_q;
    assign up_read_addr = upAddr_q;
    assign read_data    = readData_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_maxpool2d_2x2_stride2_1x_64ch.sv
// tb_maxpool2d_2x2_stride2_1x_64ch
//
// Purpose:
//    Self-checking bench for the 2x2 stride-2 max-pool stage. It models the
//    upstream layer (start/done handshake plus a one-cycle-latency nibble
//    memory) and predicts every pooled value directly from the upstream map.
//
// Ports: none (top-level bench).
module tb_maxpool2d_2x2_stride2_1x_64ch;

    localparam int IN_W    = 16;
    localparam int IN_H    = 16;
    localparam int CH      = 64;
    localparam int OW      = IN_W / 2;
    localparam int OH      = IN_H / 2;
    localparam int NIN     = CH * IN_W * IN_H;
    localparam int NOUT    = CH * OW * OH;
    localparam int RUN_LAT = 6 * NOUT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        up_start;
    logic        up_done;
    logic [31:0] up_read_addr;
    logic [3:0]  up_read_data;
    logic [31:0] read_addr;
    logic [3:0]  read_data;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;
    int upStartCount = 0;
    int doneCount    = 0;

    logic [3:0] upMem [NIN];
    logic [3:0] expA  [NOUT];
    logic [3:0] expB  [NOUT];

    always #5 clk = ~clk;

    maxpool2d_2x2_stride2_1x_64ch dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .up_start    (up_start),
        .up_done     (up_done),
        .up_read_addr(up_read_addr),
        .up_read_data(up_read_data),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .busy        (busy),
        .done        (done)
    );

    // Upstream layer read port: registered, so data follows the address by one cycle.
    always @(posedge clk) begin
        up_read_data <= (up_read_addr < NIN) ? upMem[up_read_addr[13:0]] : 4'h0;
    end

    // Pulse counters used to prove spurious starts and up_done pulses do nothing.
    always @(negedge clk) begin
        if (up_start === 1'b1) upStartCount++;
        if (done === 1'b1)     doneCount++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: maximum of the four upstream pixels covering pooled element idx.
    function automatic logic [3:0] poolRef(input int idx);
        int ch, r, c;
        logic [3:0] m, v;
        ch = idx / (OW * OH);
        r  = (idx % (OW * OH)) / OW;
        c  = idx % OW;
        m  = 4'd0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                v = upMem[ch*IN_W*IN_H + (2*r+dr)*IN_W + 2*c + dc];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic readNibble(input int addr, output logic [3:0] value);
        read_addr = 32'(addr);
        @(negedge clk);
        value = read_data;
    endtask

    // One full run: start, upstream handshake, wait for done with a cycle budget.
    // The latency counts both the up_done cycle and the done cycle.
    task automatic applyStimulus(input string tag, input bit glitch, input bit readDuring);
        int  startsBefore, donesBefore, lat, rdAddr;
        bit  seen, rdPending, ok;
        logic [3:0] v;
        startsBefore = upStartCount;
        donesBefore  = doneCount;
        rdPending    = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " up_start pulse"}, up_start, 1);
        check({tag, " busy after start"}, busy, 1);
        @(negedge clk);
        check({tag, " up_start single"}, up_start, 0);
        if (glitch) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        up_done = 1'b1;
        lat  = 1;
        seen = 1'b0;
        while (lat < RUN_LAT + 50) begin
            @(negedge clk);
            lat++;
            if (lat == 2) up_done = 1'b0;
            if (glitch && lat == 200) begin start = 1'b1; up_done = 1'b1; end
            if (glitch && lat == 201) begin start = 1'b0; up_done = 1'b0; end
            if (readDuring && rdPending && (lat % 16 == 1)) begin
                v  = read_data;
                ok = !$isunknown(v) && (v == expA[rdAddr] || v == expB[rdAddr]);
                check($sformatf("%s mid-run read[%0d]", tag, rdAddr), ok, 1);
                rdPending = 1'b0;
            end
            if (readDuring && (lat % 16 == 0)) begin
                rdAddr    = int'($urandom_range(0, NOUT - 1));
                read_addr = 32'(rdAddr);
                rdPending = 1'b1;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, seen, 1);
        check({tag, " latency"}, lat, RUN_LAT);
        check({tag, " busy in done cycle"}, busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after done"}, busy, 0);
        check({tag, " done single"}, done, 0);
        repeat (2) @(negedge clk);
        check({tag, " start in done ignored"}, {up_start, busy}, 0);
        check({tag, " up_start count"}, upStartCount - startsBefore, 1);
        check({tag, " done count"}, doneCount - donesBefore, 1);
    endtask

    // Sweeps every pooled element with one read in flight per cycle.
    task automatic checkOutput(input string tag, input bit useB);
        logic [3:0] e;
        @(negedge clk);
        for (int i = 0; i <= NOUT; i++) begin
            if (i > 0) begin
                e = useB ? expB[i-1] : expA[i-1];
                check($sformatf("%s[%0d]", tag, i - 1), read_data, e);
            end
            if (i < NOUT) read_addr = 32'(i);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0]  nib;
        logic [31:0] word;
        int r, c, tap, sel;

        reset     = 1'b1;
        start     = 1'b0;
        up_done   = 1'b0;
        read_addr = '0;

        // Data set A: ch0 constant 5, ch1..31 diagonal ramp, ch32..47 a lone 9
        // walking through the taps (every fifth window all zero), rest random.
        for (int ch = 0; ch < CH; ch++) begin
            for (int row = 0; row < IN_H; row++) begin
                for (int col = 0; col < IN_W; col++) begin
                    r   = row / 2;
                    c   = col / 2;
                    tap = (row % 2) * 2 + (col % 2);
                    sel = (r * OW + c) % 5;
                    if (ch == 0)       upMem[ch*IN_W*IN_H + row*IN_W + col] = 4'd5;
                    else if (ch < 32)  upMem[ch*IN_W*IN_H + row*IN_W + col] = 4'((ch + row + col) % 16);
                    else if (ch < 48)  upMem[ch*IN_W*IN_H + row*IN_W + col] = (sel == tap) ? 4'd9 : 4'd0;
                    else               upMem[ch*IN_W*IN_H + row*IN_W + col] = 4'($urandom_range(0, 15));
                end
            end
        end
        for (int i = 0; i < NOUT; i++) expA[i] = poolRef(i);
        for (int i = 0; i < NOUT; i++) expB[i] = expA[i];

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset up_start", up_start, 0);
        check("reset up_read_addr", up_read_addr, 0);
        check("reset read_data", read_data, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus("runA", 1'b1, 1'b0);

        word = '0;
        for (int i = 0; i < 8; i++) begin
            readNibble(i, nib);
            word = {word[27:0], nib};
        end
        check("word0 of constant plane", word, 32'h5555_5555);
        readNibble(64, nib);        check("ramp ch1 r0 c0", nib, 4'd3);
        readNibble(14 * 64, nib);   check("ramp ch14 r0 c0 wrap", nib, 4'd15);
        readNibble(31 * 64 + 63, nib); check("ramp ch31 r7 c7", nib, 4'd13);
        readNibble(2048, nib);      check("lone 9 at tap0", nib, 4'd9);
        readNibble(2049, nib);      check("lone 9 at tap1", nib, 4'd9);
        readNibble(2050, nib);      check("lone 9 at tap2", nib, 4'd9);
        readNibble(2051, nib);      check("lone 9 at tap3", nib, 4'd9);
        readNibble(2052, nib);      check("all-zero window", nib, 4'd0);
        readNibble(NOUT + 5, nib);  check("out of range read", nib, 4'd0);
        checkOutput("runA", 1'b0);

        // Data set B: fully random, so a second run must overwrite set A.
        for (int i = 0; i < NIN; i++) upMem[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < NOUT; i++) expB[i] = poolRef(i);

        // Abort a run asynchronously while it reads tap 2 of pooled pixel 20.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        up_done = 1'b1;
        @(negedge clk);
        up_done = 1'b0;
        repeat (122) @(negedge clk);
        check("abort at tap2 address", up_read_addr, 32'((2 * 2 + 1) * IN_W + 2 * 4));
        check("abort busy before reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        check("async reset up_start", up_start, 0);
        check("async reset up_read_addr", up_read_addr, 0);
        check("async reset read_data", read_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus("runB", 1'b0, 1'b1);
        checkOutput("runB", 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
